// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO, character counter
// and sticky framing/overflow flags.
module uart_rx_capture #(
  parameter int unsigned CLKS_PER_BIT = 32,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_i,
  input  logic        rx_en_i,
  input  logic        clr_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        frame_err_o,
  output logic        overflow_o,
  output logic [31:0] char_cnt_o
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          sync1_q, sync2_q;
  logic          rxs;
  logic          push_req, ferr_set;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          empty, full, pop, push, drop;

  assign rxs = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // Timer restarts at every sample point so each state counts from zero.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TW'(1);
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (rx_en_i && !rxs) begin
          state_d = START;
          bit_d   = '0;
        end
      end
      START: begin
        if (timer_q == HALF_M1) begin
          timer_d = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          shreg_d = {rxs, shreg_q[7:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          if (rxs) begin
            push_req = 1'b1;
            state_d  = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        timer_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty = (wr_q == rd_q);
  assign full  = ((wr_q - rd_q) == (AW+1)'(FIFO_DEPTH));
  assign pop   = !empty && ready_i;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push  = push_req && (!full || pop) && !clr_i;
  assign drop  = push_req && full && !pop && !clr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
      char_cnt_o  <= '0;
    end else if (clr_i) begin
      wr_q        <= '0;
      rd_q        <= '0;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
      char_cnt_o  <= '0;
    end else begin
      if (push) begin
        wr_q       <= wr_q + (AW+1)'(1);
        char_cnt_o <= char_cnt_o + 32'd1;
      end
      if (pop)      rd_q        <= rd_q + (AW+1)'(1);
      if (ferr_set) frame_err_o <= 1'b1;
      if (drop)     overflow_o  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q[AW-1:0]] <= shreg_q;
    end
  end

  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign valid_o = !empty;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Scoreboard bench for uart_rx_capture: directed 8N1 frames, popped bytes
// compared against an expected-byte queue by an independent monitor.
module tb_uart_rx_capture;

  localparam int unsigned C = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_i, rx_en_i, clr_i, ready_i;
  logic [7:0]  data_o;
  logic        valid_o, frame_err_o, overflow_o;
  logic [31:0] char_cnt_o;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  exp_q [$];

  uart_rx_capture #(.CLKS_PER_BIT(C), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .rx_en_i(rx_en_i), .clr_i(clr_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .frame_err_o(frame_err_o), .overflow_o(overflow_o), .char_cnt_o(char_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected none", data_o);
      end else begin
        check("pop_data", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    rx_i = 1'b1;
    wait_cyc(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_i = 1'b0;
    wait_cyc(C);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      wait_cyc(C);
    end
    rx_i = stop;
    wait_cyc(C);
  endtask

  task automatic clr_pulse();
    clr_i = 1'b1;
    wait_cyc(1);
    clr_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] partial;
    rst_n = 1'b0; rx_i = 1'b1; rx_en_i = 1'b1; clr_i = 1'b0; ready_i = 1'b1;
    wait_cyc(3);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_data", {24'd0, data_o}, 32'd0);
    check("rst_ferr", {31'd0, frame_err_o}, 32'd0);
    check("rst_ovf", {31'd0, overflow_o}, 32'd0);
    check("rst_cnt", char_cnt_o, 32'd0);
    rst_n = 1'b1;
    idle(4);

    // 1: single byte with exact push latency (rxs low 2 cycles after drive -> Ts+1 = 307)
    exp_q.push_back(8'h65);
    fork
      send_frame(8'h65, 1'b1);
      begin
        repeat (306) @(posedge clk);
        #1;
        check("t1_valid_pre", {31'd0, valid_o}, 32'd0);
        check("t1_cnt_pre", char_cnt_o, 32'd0);
        @(posedge clk);
        #1;
        check("t1_valid", {31'd0, valid_o}, 32'd1);
        check("t1_data", {24'd0, data_o}, 32'h65);
        check("t1_cnt", char_cnt_o, 32'd1);
      end
    join
    idle(32);
    check("t1_ferr", {31'd0, frame_err_o}, 32'd0);
    check("t1_ovf", {31'd0, overflow_o}, 32'd0);
    check("t1_qempty", exp_q.size(), 32'd0);

    // 2: false start
    clr_pulse();
    check("t2_clr_cnt", char_cnt_o, 32'd0);
    rx_i = 1'b0;
    wait_cyc(8);
    idle(64);
    check("t2_cnt", char_cnt_o, 32'd0);
    check("t2_valid", {31'd0, valid_o}, 32'd0);

    // 3: framing error, break, then a good byte
    send_frame(8'h38, 1'b0);
    wait_cyc(100);
    idle(64);
    check("t3_ferr", {31'd0, frame_err_o}, 32'd1);
    check("t3_cnt_bad", char_cnt_o, 32'd0);
    exp_q.push_back(8'h38);
    send_frame(8'h38, 1'b1);
    idle(32);
    check("t3_cnt", char_cnt_o, 32'd1);
    check("t3_ferr_sticky", {31'd0, frame_err_o}, 32'd1);
    check("t3_qempty", exp_q.size(), 32'd0);

    // 4: overflow with 17 bytes, then drain
    clr_pulse();
    check("t4_clr_ferr", {31'd0, frame_err_o}, 32'd0);
    ready_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
      idle(16);
    end
    check("t4_ovf", {31'd0, overflow_o}, 32'd1);
    check("t4_cnt", char_cnt_o, 32'd16);
    check("t4_head", {24'd0, data_o}, 32'h00);
    ready_i = 1'b1;
    wait_cyc(20);
    check("t4_qempty", exp_q.size(), 32'd0);
    check("t4_valid", {31'd0, valid_o}, 32'd0);

    // 5: full FIFO, pop and push in the same cycle
    clr_pulse();
    ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h80 + 8'(i));
      send_frame(8'h80 + 8'(i), 1'b1);
      idle(16);
    end
    check("t5_ovf_pre", {31'd0, overflow_o}, 32'd0);
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (306) @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    idle(32);
    check("t5_ovf", {31'd0, overflow_o}, 32'd0);
    check("t5_cnt", char_cnt_o, 32'd17);
    check("t5_qempty", exp_q.size(), 32'd0);

    // 6: async reset during DATA bit 4
    partial = 8'h3C;
    rx_i = 1'b0;
    wait_cyc(C);
    for (int i = 0; i < 4; i++) begin
      rx_i = partial[i];
      wait_cyc(C);
    end
    rx_i = 1'b1;
    wait_cyc(8);
    rst_n = 1'b0;
    wait_cyc(2);
    check("t6_rst_cnt", char_cnt_o, 32'd0);
    check("t6_rst_valid", {31'd0, valid_o}, 32'd0);
    rst_n = 1'b1;
    idle(400);
    check("t6_no_spurious", char_cnt_o, 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(32);
    check("t6_cnt", char_cnt_o, 32'd1);
    check("t6_ferr", {31'd0, frame_err_o}, 32'd0);
    check("t6_ovf", {31'd0, overflow_o}, 32'd0);
    check("t6_qempty", exp_q.size(), 32'd0);
    ready_i = 1'b0;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    idle(16);
    check("t6_valid_held", {31'd0, valid_o}, 32'd1);
    clr_pulse();
    void'(exp_q.pop_front());
    check("t6_clr_cnt", char_cnt_o, 32'd0);
    check("t6_clr_valid", {31'd0, valid_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
